// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between fetch (if_*) and load/store (ls_*) requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed ls-over-if priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_ls_q, owner_ls_d;
  logic              if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_ls;

`ifdef MEM_ARB_RR_EN
  // Set when ls was granted last; cleared at reset so ls wins the first tie.
  logic last_ls_q, last_ls_d;
  assign pick_ls = ls_req && (!if_req || !last_ls_q);
`else
  assign pick_ls = ls_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_ls_d  = owner_ls_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d   = last_ls_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (if_req || ls_req) begin
          state_d    = StIssue;
          owner_ls_d = pick_ls;
          mem_en_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_ls_d  = pick_ls;
`endif
          if (pick_ls) begin
            ls_gnt_d    = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
          end else begin
            if_gnt_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      StIssue: begin
        if (mem_we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = 3'(RD_LAT);
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        // Data is valid on this edge; rvalid appears while the FSM is back in IDLE.
        if (cnt_q == 3'd1) begin
          state_d = StIdle;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      owner_ls_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_ls_q  <= owner_ls_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q   <= last_ls_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3, each with a memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // RD_LAT=1 instance
  logic        if_req, ls_req, ls_we;
  logic [9:0]  if_addr, ls_addr;
  logic [31:0] ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  // RD_LAT=3 instance
  logic        if_req3;
  logic [9:0]  if_addr3;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;
  logic        zero1 = 1'b0;
  logic [9:0]  zero10 = '0;
  logic [31:0] zero32 = '0;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
    .if_rdata(if_rdata3),
    .ls_req(zero1), .ls_we(zero1), .ls_addr(zero10), .ls_wdata(zero32), .ls_gnt(ls_gnt3),
    .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models; preload happens while reset is held.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem1[10'h010] <= 32'hDEADBEEF;
      mem3[10'h001] <= 32'hCAFEF00D;
    end else begin
      if (mem_en) begin
        if (mem_we) mem1[mem_addr] <= mem_wdata;
        else pipe1 <= mem1[mem_addr];
      end
      if (mem_en3 && !mem_we3) pipe3[0] <= mem3[mem_addr3];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    if_req3 = 0; if_addr3 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we, mem_addr,
         mem_wdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero output(s), required all 0");
    end
    @(negedge clk);
    rst_n = 1;
    step();
    n_checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b mem_en=%b required 0 0", busy, mem_en);
    end
  endtask

  task automatic test_fetch_read();
    if_req = 1; if_addr = 10'h010;
    step();
    n_checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 10'h010, 1'b1})
    begin
      n_fail++;
      $display("FAIL fetch_grant: gnt=%b/%b en=%b we=%b addr=%h busy=%b required 1/0 1 0 010 1",
               if_gnt, ls_gnt, mem_en, mem_we, mem_addr, busy);
    end
    if_req = 0;
    step();
    n_checks++;
    if ({if_gnt, mem_en, if_rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL fetch_issue_exit: gnt=%b en=%b rvalid=%b required 000", if_gnt, mem_en,
               if_rvalid);
    end
    step();
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || ls_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_rvalid: rvalid=%b rdata=%h ls_rvalid=%b required 1 deadbeef 0",
               if_rvalid, if_rdata, ls_rvalid);
    end
    step();
    n_checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_hold: rvalid=%b rdata=%h required 0 deadbeef", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store_load();
    int rv;
    ls_req = 1; ls_we = 1; ls_addr = 10'h020; ls_wdata = 32'h12345678;
    step();
    n_checks++;
    if ({ls_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 10'h020, 32'h12345678}) begin
      n_fail++;
      $display("FAIL store_grant: gnt=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 020 12345678",
               ls_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ls_req = 0;
    rv = 0;
    repeat (3) begin
      step();
      if (ls_rvalid || mem_en || ls_gnt) rv++;
    end
    n_checks++;
    if (rv != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL store_no_rvalid: activity cycles=%0d busy=%b required 0 0", rv, busy);
    end
    ls_req = 1; ls_we = 0; ls_addr = 10'h020;
    step();
    n_checks++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_grant: gnt=%b we=%b required 1 0", ls_gnt, mem_we);
    end
    ls_req = 0;
    step();
    step();
    n_checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h12345678 || if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_data: rvalid=%b rdata=%h required 1 12345678", ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] order, exp_order;
    int n;
    int both;
    apply_reset();
    if_req = 1; if_addr = 10'h010; ls_req = 1; ls_we = 0; ls_addr = 10'h020;
    step();
    n_checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_first_ls: ls_gnt=%b if_gnt=%b required 1 0", ls_gnt, if_gnt);
    end
    ls_req = 0;
    step();
    step();
    n_checks++;
    if (ls_rvalid !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_ls_rvalid: ls_rvalid=%b if_gnt=%b required 1 0", ls_rvalid, if_gnt);
    end
    step();
    n_checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 10'h010) begin
      n_fail++;
      $display("FAIL sim_if_after: if_gnt=%b addr=%h required 1 010", if_gnt, mem_addr);
    end
    if_req = 0;
    step();
    step();

    // Both held for four transactions
    apply_reset();
    if_req = 1; if_addr = 10'h010; ls_req = 1; ls_we = 0; ls_addr = 10'h020;
    order = '0; n = 0; both = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) both++;
      if (ls_gnt) begin order[3-n] = 1'b1; n++; end
      else if (if_gnt) begin order[3-n] = 1'b0; n++; end
    end
    if_req = 0; ls_req = 0;
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    n_checks++;
    if (n != 4 || order !== exp_order || both != 0) begin
      n_fail++;
      $display("FAIL sim_order: grants=%0d order(1=ls)=%b overlaps=%0d required 4 %b 0", n, order,
               exp_order, both);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_read();
    int rv;
    if_req = 1; if_addr = 10'h010;
    step();
    if_req = 0;
    step();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we, mem_addr,
         mem_wdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs nonzero immediately after rst_n fall, required all 0");
    end
    @(negedge clk);
    rst_n = 1;
    rv = 0;
    repeat (10) begin
      step();
      if (if_rvalid || ls_rvalid) rv++;
    end
    n_checks++;
    if (rv != 0) begin
      n_fail++;
      $display("FAIL reset_discard: rvalid cycles=%0d required 0", rv);
    end
    if_req = 1; if_addr = 10'h010;
    step();
    if_req = 0;
    step();
    step();
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_recover: rvalid=%b rdata=%h required 1 deadbeef", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] gnts;
    logic prev_en;
    int dbl;
    step();
    ls_req = 1; ls_we = 1; ls_addr = 10'h030; ls_wdata = 32'h00000055;
    gnts = '0; dbl = 0; prev_en = mem_en;
    for (int k = 0; k < 6; k++) begin
      step();
      gnts[5-k] = ls_gnt;
      if (prev_en && mem_en) dbl++;
      prev_en = mem_en;
    end
    ls_req = 0;
    n_checks++;
    if (gnts !== 6'b101010 || dbl != 0) begin
      n_fail++;
      $display("FAIL b2b_stores: gnt pattern=%b double_en=%0d required 101010 0", gnts, dbl);
    end
    step();
  endtask

  task automatic test_rd_lat3();
    logic [4:0] bz, rvs;
    if_req3 = 1; if_addr3 = 10'h001;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) if_req3 = 0;
      bz[4-k]  = busy3;
      rvs[4-k] = if_rvalid3;
    end
    n_checks++;
    if (bz !== 5'b11110 || rvs !== 5'b00001) begin
      n_fail++;
      $display("FAIL lat3_timing: busy=%b rvalid=%b required 11110 00001", bz, rvs);
    end
    n_checks++;
    if (if_rdata3 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL lat3_data: rdata=%h required cafef00d", if_rdata3);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_read();
    test_store_load();
    test_rd_lat3();
    test_back_to_back();
    test_reset_mid_read();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
